// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and width helpers for the word serializer
package axis_pkg;

  // Serializer control state: no word held, or word held and beats going out.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Number of output beats per parallel word.
  function automatic int beats_of(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  // Beat counter width: clog2 of the beat count, never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  // The word must split into a whole, non-zero number of beats.
  function automatic bit widths_ok(input int word_w, input int data_w);
    return (data_w > 0) && (word_w >= data_w) && ((word_w % data_w) == 0);
  endfunction

endpackage

// File: rtl/axis_word_serializer_if.sv
// rtl/axis_word_serializer_if.sv - stream handshake bundle with master/slave views
interface axis_word_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_word_serializer.sv
// rtl/axis_word_serializer.sv - wide word to narrow beat serializer; tlast gated by AXIS_SERIALIZER_LAST_EN
module axis_word_serializer
  import axis_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_word_serializer_if.slave   s_word,
  axis_word_serializer_if.master  m_axis
);

  localparam int BEATS = beats_of(WORD_WIDTH, DATA_WIDTH);
  localparam int CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (!widths_ok(WORD_WIDTH, DATA_WIDTH)) begin : g_width_check
    $fatal(1, "axis_word_serializer: WORD_WIDTH must be a non-zero multiple of DATA_WIDTH");
  end

  ser_state_e            state_q, state_d;
  logic [CW-1:0]         beat_q, beat_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] head_slice;
  logic                  is_last;
  logic                  word_ready;
  logic                  word_hs;

  // The outgoing slice always sits at one end of the shift register; the
  // other end refills with zeros so an emptied register reads as 0.
  if (BEATS == 1) begin : g_single
    assign shreg_next = '0;
    assign head_slice = shreg_q;
  end else if (MSB_FIRST) begin : g_msb
    assign shreg_next = shreg_q << DATA_WIDTH;
    assign head_slice = shreg_q[WORD_WIDTH-1 -: DATA_WIDTH];
  end else begin : g_lsb
    assign shreg_next = shreg_q >> DATA_WIDTH;
    assign head_slice = shreg_q[DATA_WIDTH-1:0];
  end

  assign is_last = (beat_q == LAST_BEAT);

  // A new word may enter while idle, or on the very cycle the last beat leaves.
  assign word_ready = !rst && ((state_q == IDLE) || (is_last && m_axis.tready));
  assign word_hs    = s_word.tvalid && word_ready;

  assign s_word.tready = word_ready;
  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tdata  = head_slice;

`ifdef AXIS_SERIALIZER_LAST_EN
  assign m_axis.tlast = (state_q == SEND) && is_last;
`else
  assign m_axis.tlast = 1'b0;
`endif

  // Next-state logic: load, shift per accepted beat, reload or retire on the last beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (word_hs) begin
          shreg_d = s_word.tdata;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_axis.tready) begin
          if (!is_last) begin
            beat_d  = beat_q + CW'(1);
            shreg_d = shreg_next;
          end else if (word_hs) begin
            shreg_d = s_word.tdata;
            beat_d  = '0;
          end else begin
            shreg_d = '0;
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        shreg_d = '0;
      end
    endcase
  end

  // State registers; reset drops any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_axis_word_serializer.sv
// tb/tb_axis_word_serializer.sv - scoreboard bench for axis_word_serializer (LSB-first and MSB-first instances)
module tb_axis_word_serializer;

`ifdef AXIS_SERIALIZER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0;
  beat_t e1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_word_serializer_if #(.WIDTH(32)) w0 ();
  axis_word_serializer_if #(.WIDTH(32)) w1 ();
  axis_word_serializer_if #(.WIDTH(8))  m0 ();
  axis_word_serializer_if #(.WIDTH(8))  m1 ();

  assign w0.tdata  = s_tdata;
  assign w0.tvalid = s_tvalid;
  assign w0.tlast  = 1'b0;
  assign w1.tdata  = s_tdata;
  assign w1.tvalid = s_tvalid;
  assign w1.tlast  = 1'b0;
  assign m0.tready = m_tready;
  assign m1.tready = m_tready;

  axis_word_serializer #(.WORD_WIDTH(32), .DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .s_word(w0), .m_axis(m0)
  );

  axis_word_serializer #(.WORD_WIDTH(32), .DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .s_word(w1), .m_axis(m1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beats in LSB-first order; the MSB-first instance sees them reversed.
  task automatic expect_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    q0.push_back({b0, 1'b0});
    q0.push_back({b1, 1'b0});
    q0.push_back({b2, 1'b0});
    q0.push_back({b3, LAST_EN});
    q1.push_back({b3, 1'b0});
    q1.push_back({b2, 1'b0});
    q1.push_back({b1, 1'b0});
    q1.push_back({b0, LAST_EN});
  endtask

  task automatic accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (w0.tready === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_accept: s_word_tready stayed 0 for 20 cycles, expected 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_tvalid_lsb"}, 32'(m0.tvalid), 32'd1);
      chk({name, "_tvalid_msb"}, 32'(m1.tvalid), 32'd1);
    end
    @(negedge clk);
    chk({name, "_idle_tvalid"}, 32'(m0.tvalid), 32'd0);
    chk({name, "_q_empty"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Scoreboard monitors: a beat is consumed whenever valid and ready coincide.
  always @(negedge clk) begin
    if (!rst && m_tready && m0.tvalid) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL lsb_unexpected: beat 0x%0h arrived, expected none", m0.tdata);
      end else begin
        e0 = q0.pop_front();
        chk("lsb_tdata", 32'(m0.tdata), 32'(e0.d));
        chk("lsb_tlast", 32'(m0.tlast), 32'(e0.l));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_tready && m1.tvalid) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL msb_unexpected: beat 0x%0h arrived, expected none", m1.tdata);
      end else begin
        e1 = q1.pop_front();
        chk("msb_tdata", 32'(m1.tdata), 32'(e1.d));
        chk("msb_tlast", 32'(m1.tlast), 32'(e1.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m0.tvalid), 32'd0);
    chk("rst_tlast", 32'(m0.tlast), 32'd0);
    chk("rst_tdata", 32'(m0.tdata), 32'h00);
    chk("rst_s_tready", 32'(w0.tready), 32'd0);
    chk("rst_tvalid_msb", 32'(m1.tvalid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", 32'(w0.tready), 32'd1);

    // Single word
    @(posedge clk);
    #1;
    s_tdata = 32'h44332211;
    s_tvalid = 1'b1;
    expect_word(8'h11, 8'h22, 8'h33, 8'h44);
    accept("single");
    s_tvalid = 1'b0;
    drain("single", 4);

    // Back-to-back words
    @(posedge clk);
    #1;
    s_tdata = 32'h44332211;
    s_tvalid = 1'b1;
    expect_word(8'h11, 8'h22, 8'h33, 8'h44);
    expect_word(8'h55, 8'h66, 8'h77, 8'h88);
    accept("b2b");
    s_tdata = 32'h88776655;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_tvalid", 32'(m0.tvalid), 32'd1);
      if (i < 3) chk("b2b_s_tready_busy", 32'(w0.tready), 32'd0);
      if (i == 3) begin
        chk("b2b_s_tready_last", 32'(w0.tready), 32'd1);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle_tvalid", 32'(m0.tvalid), 32'd0);
    chk("b2b_q_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Backpressure on the third beat
    @(posedge clk);
    #1;
    s_tdata = 32'h44332211;
    s_tvalid = 1'b1;
    expect_word(8'h11, 8'h22, 8'h33, 8'h44);
    accept("bp");
    s_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_tdata", 32'(m0.tdata), 32'h33);
      chk("bp_tvalid", 32'(m0.tvalid), 32'd1);
      chk("bp_s_tready", 32'(w0.tready), 32'd0);
      chk("bp_tdata_msb", 32'(m1.tdata), 32'h22);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    drain("bp", 2);

    // Reset in the middle of a word
    @(posedge clk);
    #1;
    s_tdata = 32'h44332211;
    s_tvalid = 1'b1;
    expect_word(8'h11, 8'h22, 8'h33, 8'h44);
    accept("mid_rst");
    s_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(m0.tvalid), 32'd0);
    chk("mid_rst_tvalid_msb", 32'(m1.tvalid), 32'd0);
    chk("mid_rst_s_tready", 32'(w0.tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    s_tdata = 32'hDDCCBBAA;
    s_tvalid = 1'b1;
    expect_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    accept("after_rst");
    s_tvalid = 1'b0;
    drain("after_rst", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_word_serializer.md
# axis_word_serializer

Converts one wide parallel word into a sequence of narrow AXI4-Stream beats, marking the final beat of each word with tlast. It is the transmit-side counterpart of the stream pipeline and deframing path: it sits between the network/host result logic (e.g. spike or output-packet words) and the byte-wide stream toward UART/host TX. Full throughput is sustained, with no bubble between consecutive words.

## Interface

Parameters:
- WORD_WIDTH, 32, width of the parallel input word; must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 8, width of each output stream beat.
- MSB_FIRST, 0, 0 = least-significant slice sent first; 1 = most-significant slice first.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_word_tdata  input  WORD_WIDTH  parallel word to serialize.
- s_word_tvalid  input  1  word valid.
- s_word_tready  output  1  word accepted when tvalid && tready.
- m_axis_tdata  output  DATA_WIDTH  current beat.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final beat of a word (see Configuration).

## Operation

- BEATS = WORD_WIDTH/DATA_WIDTH (≥1); beat counter width = max(1, clog2(BEATS)).
- States: IDLE (no word held), SEND (word held, emitting beats).
- IDLE: m_axis_tvalid=0; s_word_tready=1. On word handshake: latch word, beat=0, go to SEND.
- SEND: m_axis_tvalid=1; m_axis_tdata = slice[beat] (slice k = bits k*DATA_WIDTH +: DATA_WIDTH when MSB_FIRST=0, reversed order when MSB_FIRST=1); m_axis_tlast = (beat==BEATS-1).
- Beat handshake, not last: beat increments; state stays SEND.
- Beat handshake, last beat: if s_word_tvalid is also high, the new word is latched, beat=0, and state stays SEND; otherwise go to IDLE.
- s_word_tready = !rst && (state==IDLE || (beat==BEATS-1 && m_axis_tready)). This is the only combinational input-to-output path (m_axis_tready → s_word_tready).
- No handshake: m_axis_tdata, m_axis_tlast and beat hold stable; AXIS rules apply (tvalid never drops without a handshake).
- BEATS=1: every word yields one beat with tlast=1. This acts as a single-stage register with combinational ready.
- Reset mid-word discards the held word. No partial word is completed.

## Timing

- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, state=IDLE, beat=0; s_word_tready=0 while rst is high.
- Latency: first beat is valid on the cycle after word acceptance.
- Throughput: with m_axis_tready held high, one beat per cycle. Back-to-back words are contiguous, so N words take N*BEATS cycles after the first.
- Stalls of any length are tolerated; outputs stay frozen.

## Configuration

- Macro AXIS_SERIALIZER_LAST_EN.
- Defined: m_axis_tlast is asserted on beat BEATS-1 of every word, as described above.
- Undefined: m_axis_tlast is tied to 0 and no tlast logic is generated. Serialization, counters and handshakes are unchanged.

## Structure

- Shared package axis_pkg holds:
  - the serializer state typedef (IDLE, SEND);
  - a beats/counter-width function, clog2 with a minimum of 1;
  - the elaboration check that WORD_WIDTH % DATA_WIDTH == 0, which must fail on mismatch.
- Single module; no sub-module. Slice selection is done with a shift register:
  - shift by DATA_WIDTH per beat;
  - shift direction is set by MSB_FIRST.

## Test plan

All scenarios use WORD_WIDTH=32, DATA_WIDTH=8, macro defined unless noted.
- Reset: hold rst 2 cycles → tvalid=0, tlast=0, tdata=0x00, s_word_tready=0; the cycle after release, s_word_tready=1.
- Single word 0x44332211, m_axis_tready=1 → beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after acceptance; tlast only on 0x44; then tvalid=0.
- Back-to-back words 0x44332211 and 0x88776655 → 8 contiguous beats 0x11…0x44, 0x55…0x88; s_word_tready=1 on the 0x44 cycle; tlast on 0x44 and 0x88.
- Backpressure: m_axis_tready low for 3 cycles while 0x33 is presented → tdata=0x33, tvalid=1, s_word_tready=0 stable throughout; then 0x33 and 0x44 complete.
- Reset after the 0x22 beat → tvalid=0 the next cycle; the following word 0xDDCCBBAA starts at 0xAA.
- MSB_FIRST=1, word 0x44332211 → beats 0x44, 0x33, 0x22, 0x11, tlast on 0x11. With the macro undefined, tlast stays 0 throughout.
